bmem_burst_adapter: RTL and testbench
=====================================

# bmem_burst_adapter

Converts 256-bit cache-line requests from the memory arbiter into 4-beat 64-bit bursts on the backend memory bus. It sits directly downstream of the arbiter, which sees it as the "cache adapter". It collects read beats into a full line and returns it with a one-cycle `r_resp`. It serializes write lines into beats and returns a one-cycle `w_resp` after the last beat is accepted. One transaction is in flight at a time.

## Interface
- `BEAT_W`, 64, data width of one backend beat.
- `BEATS`, 4, beats per line; `BEATS*BEAT_W` must equal 256.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `line_addr`  in  32  line address from the arbiter; bits [4:0] are ignored (treated as 0).
- `line_read`  in  1  line read request; the arbiter holds it level until it sees `r_resp`.
- `line_write`  in  1  line write request; the arbiter holds it level until it sees `w_resp`.
- `line_wdata`  in  256  write line; beat k is bits [64k+63:64k].
- `r_resp`  out  1  one-cycle pulse: `line_rdata` is valid.
- `w_resp`  out  1  one-cycle pulse: the write completed.
- `line_rdata`  out  256  assembled read line.
- `line_raddr`  out  32  aligned address of the returned line.
- `bmem_addr`  out  32  aligned burst address.
- `bmem_read`  out  1  read burst request.
- `bmem_write`  out  1  write beat valid.
- `bmem_wdata`  out  64  current write beat.
- `bmem_ready`  in  1  backend accepts the read request, or accepts the current write beat.
- `bmem_rvalid`  in  1  read beat valid.
- `bmem_rdata`  in  64  read beat data.
- `bmem_raddr`  in  32  aligned address tag of the read beat.

## Operation
- State machine: IDLE, RD_REQ, RD_DATA, RD_DONE, WR, WR_DONE.
- Internal registers:
  - `addr_q`: 32 bits; bits [4:0] forced to 0.
  - `buf_q`: 256 bits; shared by read and write data.
  - `cnt_q`: 2 bits; beat index.
- IDLE:
  - If `line_write`: capture `addr_q` and `buf_q<=line_wdata`, set `cnt_q=0`, go to WR.
  - Else if `line_read`: capture `addr_q`, set `cnt_q=0`, go to RD_REQ.
  - Write has priority when both are asserted.
- RD_REQ:
  - Drive `bmem_read=1`, `bmem_addr=addr_q`.
  - On `bmem_ready`, go to RD_DATA.
- RD_DATA:
  - `bmem_read=0`.
  - A beat is accepted when `bmem_rvalid && bmem_raddr==addr_q`: write it to slot `cnt_q` of `buf_q`, then increment `cnt_q`.
  - `rvalid` with a mismatched tag is dropped; state and `cnt_q` are unchanged.
  - Accepting beat 3 (`cnt_q` wraps 3->0) moves to RD_DONE.
- RD_DONE:
  - `r_resp=1`, `line_rdata=buf_q`, `line_raddr=addr_q`.
  - Go to IDLE unconditionally.
- WR:
  - Drive `bmem_write=1`, `bmem_addr=addr_q`, `bmem_wdata=buf_q` slot `cnt_q`.
  - On `bmem_ready`, increment `cnt_q`. Acceptance of beat 3 moves to WR_DONE.
  - `bmem_write` stays high across beats with no bubble while `bmem_ready` is held.
- WR_DONE: `w_resp=1`, go to IDLE.
- Request inputs are sampled only in IDLE. Changes to `line_*` mid-transaction have no effect.
- All outputs are decoded from registered state and data. No combinational path from any input to any output.
  - `line_rdata` and `line_raddr` read 0 outside RD_DONE.
  - `bmem_wdata` reads 0 outside WR.
- `rvalid` outside RD_DATA is ignored.

## Timing
- Reset: state IDLE. All outputs are 0 in the cycle after the reset edge: `r_resp`, `w_resp`, `bmem_read`, `bmem_write`, `line_rdata`, `line_raddr`, `bmem_addr`, `bmem_wdata`. `buf_q`, `addr_q` and `cnt_q` are cleared.
- Reset mid-transaction aborts it:
  - No response is issued.
  - The bus request drops the next cycle.
  - Late beats are ignored.
- Read latency:
  - Request seen in IDLE at cycle T.
  - `bmem_read` is high from T+1 until the ready cycle inclusive.
  - `r_resp` is high exactly one cycle after the cycle in which beat 3 is accepted.
- Minimum read time (ready at T+1, beats at T+2..T+5): `r_resp` at T+6.
- Minimum write time (ready held high): beats at T+1..T+4, `w_resp` at T+5.
- Back-to-back requests: the arbiter drops its request in the response cycle, so the adapter is in IDLE the following cycle. A new request can be captured the cycle after the response; the adapter adds no dead cycle beyond that.
- `bmem_read` is never high in the same cycle as `bmem_write`.
- `r_resp` and `w_resp` are never high in the same cycle.

## Test plan
- Read, zero-wait:
  - Stimulus: `line_read` with `line_addr=0x0000_1234`; ready at T+1; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: `bmem_addr=0x0000_1220`; `r_resp` at T+6; `line_rdata={0x44..,0x33..,0x22..,0x11..}`; `line_raddr=0x0000_1220`.
- Read, stalled and tagged:
  - Stimulus: ready delayed 3 cycles; one `rvalid` inserted with `bmem_raddr=0x0000_2000` between beats 1 and 2.
  - Required: the stray beat is dropped; the line is correct; `r_resp` is high one cycle after the 4th matching beat.
- Write, ready toggling 1,0,1,0,1,1:
  - Stimulus: `line_wdata` beats A,B,C,D.
  - Required: `bmem_wdata` holds each beat until accepted; observed sequence A,B,C,D; `w_resp` pulses once, one cycle after beat D is accepted.
- Simultaneous `line_read` and `line_write` in IDLE:
  - Required: a write burst is issued; no `bmem_read` occurs.
- Back-to-back:
  - Stimulus: read, then a write requested in the cycle after `r_resp`.
  - Required: `bmem_write` rises 1 cycle after the write request; no spurious second `r_resp`.
- Reset in RD_DATA after 2 beats:
  - Required: all outputs are 0 next cycle; no `r_resp`; the remaining beats are ignored; the next read completes normally.

Source files
------------

// File: rtl/bmem_burst_adapter.sv
// bmem_burst_adapter: bridges 256-bit line requests to 4-beat 64-bit backend bursts.
module bmem_burst_adapter #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               line_addr,
  input  logic                      line_read,
  input  logic                      line_write,
  input  logic [BEATS*BEAT_W-1:0]   line_wdata,
  output logic                      r_resp,
  output logic                      w_resp,
  output logic [BEATS*BEAT_W-1:0]   line_rdata,
  output logic [31:0]               line_raddr,
  output logic [31:0]               bmem_addr,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_W-1:0]         bmem_wdata,
  input  logic                      bmem_ready,
  input  logic                      bmem_rvalid,
  input  logic [BEAT_W-1:0]         bmem_rdata,
  input  logic [31:0]               bmem_raddr
);
  localparam int LW = BEATS * BEAT_W;
  localparam int CW = $clog2(BEATS);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, RD_DONE, WR, WR_DONE} state_t;
  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [LW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last;
  assign last = cnt_q == CW'(BEATS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          addr_d  = line_addr & ~32'h1f;
          buf_d   = line_wdata;
          cnt_d   = '0;
          state_d = WR;
        end else if (line_read) begin
          addr_d  = line_addr & ~32'h1f;
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: state_d = bmem_ready ? RD_DATA : RD_REQ;
      RD_DATA: begin
        // beats tagged for another line are dropped without advancing
        if (bmem_rvalid && bmem_raddr == addr_q) begin
          buf_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
          cnt_d   = cnt_q + 1'b1;
          state_d = last ? RD_DONE : RD_DATA;
        end
      end
      WR: begin
        if (bmem_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = last ? WR_DONE : WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign r_resp     = state_q == RD_DONE;
  assign w_resp     = state_q == WR_DONE;
  assign bmem_read  = state_q == RD_REQ;
  assign bmem_write = state_q == WR;
  assign line_rdata = r_resp ? buf_q : '0;
  assign line_raddr = r_resp ? addr_q : '0;
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? buf_q[cnt_q*BEAT_W +: BEAT_W] : '0;
endmodule

// File: tb/tb_bmem_burst_adapter.sv
// tb_bmem_burst_adapter: directed checks of read/write bursts, priority, back-to-back and reset abort.
module tb_bmem_burst_adapter;
  logic         clk = 0;
  logic         rst = 1;
  logic [31:0]  line_addr = 0;
  logic         line_read = 0;
  logic         line_write = 0;
  logic [255:0] line_wdata = 0;
  logic         r_resp, w_resp;
  logic [255:0] line_rdata;
  logic [31:0]  line_raddr, bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 0;
  logic         bmem_rvalid = 0;
  logic [63:0]  bmem_rdata = 0;
  logic [31:0]  bmem_raddr = 0;
  int n_chk = 0;
  int n_fail = 0;
  bmem_burst_adapter dut (
    .clk(clk), .rst(rst), .line_addr(line_addr), .line_read(line_read),
    .line_write(line_write), .line_wdata(line_wdata), .r_resp(r_resp),
    .w_resp(w_resp), .line_rdata(line_rdata), .line_raddr(line_raddr),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rvalid(bmem_rvalid),
    .bmem_rdata(bmem_rdata), .bmem_raddr(bmem_raddr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_excl", 256'(bmem_read & bmem_write), 0);
      chk("resp_excl", 256'(r_resp & w_resp), 0);
    end
  end
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_r_resp"}, 256'(r_resp), 0);
    chk({tag, "_w_resp"}, 256'(w_resp), 0);
    chk({tag, "_bmem_read"}, 256'(bmem_read), 0);
    chk({tag, "_bmem_write"}, 256'(bmem_write), 0);
    chk({tag, "_line_rdata"}, line_rdata, 0);
    chk({tag, "_line_raddr"}, 256'(line_raddr), 0);
    chk({tag, "_bmem_addr"}, 256'(bmem_addr), 0);
    chk({tag, "_bmem_wdata"}, 256'(bmem_wdata), 0);
  endtask
  task automatic rd_line(input [31:0] a, input [31:0] al, input int rdy_dly, input bit stray,
                         input [255:0] line);
    line_read = 1;
    line_addr = a;
    tick;
    for (int i = 0; i < rdy_dly; i++) begin
      chk("rd_req_hold", 256'(bmem_read), 1);
      tick;
    end
    chk("rd_req", 256'(bmem_read), 1);
    chk("rd_addr", 256'(bmem_addr), 256'(al));
    bmem_ready = 1;
    tick;
    bmem_ready = 0;
    chk("rd_req_drop", 256'(bmem_read), 0);
    for (int k = 0; k < 4; k++) begin
      if (stray && k == 2) begin
        bmem_rvalid = 1;
        bmem_raddr = 32'h0000_2000;
        bmem_rdata = 64'hdead_beef_dead_beef;
        tick;
        chk("rd_stray_no_resp", 256'(r_resp), 0);
      end
      bmem_rvalid = 1;
      bmem_raddr = al;
      bmem_rdata = line[k*64 +: 64];
      tick;
      if (k < 3) chk("rd_early_resp", 256'(r_resp), 0);
    end
    bmem_rvalid = 0;
    chk("rd_resp", 256'(r_resp), 1);
    chk("rd_data", line_rdata, line);
    chk("rd_raddr", 256'(line_raddr), 256'(al));
    line_read = 0;
    tick;
    chk("rd_resp_once", 256'(r_resp), 0);
    chk("rd_data_clr", line_rdata, 0);
  endtask
  task automatic wr_line(input [31:0] a, input [31:0] al, input [255:0] line, input [7:0] pat,
                         input int n, input bit both);
    int b = 0;
    line_write = 1;
    line_read = both;
    line_addr = a;
    line_wdata = line;
    tick;
    for (int i = 0; i < n && b < 4; i++) begin
      chk("wr_valid", 256'(bmem_write), 1);
      chk("wr_no_read", 256'(bmem_read), 0);
      chk("wr_addr", 256'(bmem_addr), 256'(al));
      chk("wr_beat", 256'(bmem_wdata), 256'(line[b*64 +: 64]));
      chk("wr_no_resp", 256'(w_resp | r_resp), 0);
      bmem_ready = pat[i];
      tick;
      if (pat[i]) b++;
    end
    bmem_ready = 0;
    chk("wr_beats", 256'(b), 4);
    chk("wr_resp", 256'(w_resp), 1);
    chk("wr_done_no_write", 256'(bmem_write), 0);
    line_write = 0;
    line_read = 0;
    tick;
    chk("wr_resp_once", 256'(w_resp), 0);
    chk("wr_after_no_read", 256'(bmem_read), 0);
  endtask
  localparam logic [255:0] L1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] L2 = {64'h0123_4567_89ab_cdef, 64'hfeed_face_cafe_f00d,
                                 64'h5555_aaaa_5555_aaaa, 64'h0000_0001_8000_0000};
  localparam logic [255:0] LW = {64'hdddd_0000_dddd_0003, 64'hcccc_0000_cccc_0002,
                                 64'hbbbb_0000_bbbb_0001, 64'haaaa_0000_aaaa_0000};
  initial begin
    tick;
    tick;
    chk_idle_outs("reset");
    rst = 0;
    tick;
    chk_idle_outs("idle");
    rd_line(32'h0000_1234, 32'h0000_1220, 0, 0, L1);
    rd_line(32'h0000_405f, 32'h0000_4040, 3, 1, L2);
    wr_line(32'h0000_8007, 32'h0000_8000, LW, 8'b0011_0101, 6, 0);
    wr_line(32'h0000_9abc, 32'h0000_9aa0, L2, 8'b0000_1111, 4, 1);
    rd_line(32'h0000_1234, 32'h0000_1220, 1, 0, L2);
    wr_line(32'h0000_c0de, 32'h0000_c0c0, L1, 8'b0000_1111, 4, 0);
    line_read = 1;
    line_addr = 32'h0000_3000;
    tick;
    bmem_ready = 1;
    tick;
    bmem_ready = 0;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1;
      bmem_raddr = 32'h0000_3000;
      bmem_rdata = L1[k*64 +: 64];
      tick;
    end
    rst = 1;
    line_read = 0;
    bmem_rdata = L1[128 +: 64];
    tick;
    rst = 0;
    chk_idle_outs("abort");
    bmem_rdata = L1[192 +: 64];
    tick;
    bmem_rvalid = 0;
    chk("abort_late_resp", 256'(r_resp), 0);
    chk("abort_late_read", 256'(bmem_read), 0);
    tick;
    chk("abort_late_resp2", 256'(r_resp), 0);
    rd_line(32'h0000_3000, 32'h0000_3000, 0, 0, L2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
